// File: rtl/jtcop_prot_bridge.sv
// -----------------------------------------------------------------------------
// jtcop_prot_bridge
//
// Purpose:
//   Bridges the main 68000 shared-window bus onto the byte-wide RAM port of the
//   protection block (HuC6280 side). Each 68000 bus cycle is turned into at
//   most one single-cycle RAM strobe. Reads return {8'hFF, ram_byte}.
//   A write to IRQ_ADDR also raises IRQ1 toward the HuC6280, which holds it
//   until irq_ack is pulsed.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   cpu_addr        68000 word address [11:1] inside the shared window
//   cpu_dout        68000 write data (only the low byte reaches the RAM)
//   cpu_din         read data back to the 68000, held between reads
//   cpu_cs          window select, high for the whole bus cycle
//   cpu_rnw         1 = read, 0 = write
//   cpu_lds_n       low byte strobe, active low
//   dtack_n         bus acknowledge, active low
//   main_addr       RAM word address toward the protection block
//   main_dout       RAM write byte
//   main_cs         RAM strobe, high for exactly one cycle per access
//   main_wrn        RAM write enable, active low, 1 whenever main_cs is 0
//   main_din        RAM read byte, valid one cycle after the strobe
//   prot_irqn       IRQ1 to the HuC6280, active low
//   irq_ack         one-cycle IRQ clear from the HuC6280 side
//
// States:
//   ST_IDLE   | waiting for cpu_cs; captures the bus cycle when it arrives
//   ST_ACCESS | RAM strobe cycle (if the low byte is selected)
//   ST_WAIT   | RAM read data in flight
//   ST_LATCH  | read byte captured into cpu_din, dtack_n asserted
//   ST_HOLD   | dtack_n held low until the 68000 drops cpu_cs
// -----------------------------------------------------------------------------
module jtcop_prot_bridge #(
    parameter logic [10:0] IRQ_ADDR = 11'h7ff
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] cpu_addr,
    input  logic [15:0] cpu_dout,
    output logic [15:0] cpu_din,
    input  logic        cpu_cs,
    input  logic        cpu_rnw,
    input  logic        cpu_lds_n,
    output logic        dtack_n,
    output logic [10:0] main_addr,
    output logic [7:0]  main_dout,
    output logic        main_cs,
    output logic        main_wrn,
    input  logic [7:0]  main_din,
    output logic        prot_irqn,
    input  logic        irq_ack
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_LATCH,
        ST_HOLD
    } state_t;

    state_t      r_state;
    logic [10:0] r_addr;
    logic [7:0]  r_data;
    logic        r_rnw;
    logic        r_lds_n;
    logic        r_cs;
    logic        r_wrn;
    logic        r_dtack_n;
    logic [15:0] r_din;
    logic        r_irqn;

    // The RAM is only byte wide; the upper data byte never goes anywhere.
    logic w_unused_hi;
    assign w_unused_hi = ^cpu_dout[15:8];

    // Low-byte write to the IRQ address during the strobe cycle raises IRQ1.
    logic w_irq_set;
    assign w_irq_set = (r_state == ST_ACCESS) && !r_rnw && !r_lds_n
                       && (r_addr == IRQ_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_data    <= '0;
            r_rnw     <= 1'b1;
            r_lds_n   <= 1'b1;
            r_cs      <= 1'b0;
            r_wrn     <= 1'b1;
            r_dtack_n <= 1'b1;
            r_din     <= 16'hFFFF;
            r_irqn    <= 1'b1;
        end else begin
            // Strobe is a one-cycle pulse; write enable idles high with it.
            r_cs  <= 1'b0;
            r_wrn <= 1'b1;

            // Ack first so that a same-cycle set (below) takes priority.
            if (irq_ack) begin
                r_irqn <= 1'b1;
            end
            if (w_irq_set) begin
                r_irqn <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (cpu_cs) begin
                        r_addr  <= cpu_addr;
                        r_data  <= cpu_dout[7:0];
                        r_rnw   <= cpu_rnw;
                        r_lds_n <= cpu_lds_n;
                        // Strobe launches together with the ACCESS state so
                        // main_cs is high during ACCESS and nowhere else.
                        r_cs    <= !cpu_lds_n;
                        r_wrn   <= cpu_lds_n | cpu_rnw;
                        r_state <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    // The strobe has already been issued, so an abort here
                    // still lets the RAM access complete; just no dtack.
                    if (!cpu_cs) begin
                        r_state <= ST_IDLE;
                    end else if (r_rnw && !r_lds_n) begin
                        r_state <= ST_WAIT;
                    end else begin
                        // Upper-byte-only reads see an open bus.
                        if (r_rnw) begin
                            r_din <= 16'hFFFF;
                        end
                        r_dtack_n <= 1'b0;
                        r_state   <= ST_HOLD;
                    end
                end

                ST_WAIT: begin
                    // main_din is valid now (one cycle after the strobe).
                    if (!cpu_cs) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_din     <= {8'hFF, main_din};
                        r_dtack_n <= 1'b0;
                        r_state   <= ST_LATCH;
                    end
                end

                ST_LATCH, ST_HOLD: begin
                    if (!cpu_cs) begin
                        r_dtack_n <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end

                default: begin
                    r_dtack_n <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_din   = r_din;
    assign dtack_n   = r_dtack_n;
    assign main_addr = r_addr;
    assign main_dout = r_data;
    assign main_cs   = r_cs;
    assign main_wrn  = r_wrn;
    assign prot_irqn = r_irqn;

endmodule

// File: doc/jtcop_prot_bridge.md
JTCOP_PROT_BRIDGE -- requirements
Module: jtcop_prot_bridge

Interface
REQ-001 SHALL have parameter: IRQ_ADDR, 11'h7ff, word address whose main-CPU write raises the protection IRQ.
REQ-002 SHALL have port: clk  input  1  system clock; only clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: cpu_addr  input  11  main 68000 word address bits [11:1] inside shared window.
REQ-005 SHALL have port: cpu_dout  input  16  68000 write data.
REQ-006 SHALL have port: cpu_din  output  16  read data returned to 68000.
REQ-007 SHALL have port: cpu_cs  input  1  decoded shared-window select, held high for the whole bus cycle.
REQ-008 SHALL have port: cpu_rnw  input  1  1=read, 0=write.
REQ-009 SHALL have port: cpu_lds_n  input  1  low byte strobe, active low.
REQ-010 SHALL have port: dtack_n  output  1  bus acknowledge to 68000, active low.
REQ-011 SHALL have ports toward the protection block: main_addr output 11, main_dout output 8, main_cs output 1, main_wrn output 1, main_din input 8 (RAM read data, 1-cycle registered latency).
REQ-012 SHALL have port: prot_irqn  output  1  IRQ1 to HuC6280, active low.
REQ-013 SHALL have port: irq_ack  input  1  one-cycle clear pulse from HuC6280 side.

Function
REQ-014 SHALL run FSM states IDLE, ACCESS, WAIT, LATCH, HOLD.
REQ-015 IDLE: on cpu_cs=1 (cycle N) SHALL register cpu_addr, cpu_dout[7:0], cpu_rnw, cpu_lds_n; go to ACCESS.
REQ-016 ACCESS (cycle N+1): SHALL drive main_cs=1 only if registered lds_n=0; main_wrn=registered rnw; main_addr/main_dout from registers; main_cs high exactly one cycle per bus cycle.
REQ-017 Write with lds_n=0: ACCESS -> HOLD; dtack_n=0 from cycle N+2.
REQ-018 Read: ACCESS -> WAIT -> LATCH; LATCH (N+3) SHALL load cpu_din={8'hFF, main_din} and drive dtack_n=0 from N+3; then HOLD.
REQ-019 Upper-byte-only access (lds_n=1): no RAM strobe; read returns 16'hFFFF, write discarded; dtack_n=0 from N+2 via ACCESS -> HOLD.
REQ-020 HOLD: dtack_n SHALL stay 0 while cpu_cs=1; first cycle cpu_cs=0 -> dtack_n=1 next cycle, state IDLE; back-to-back cycles need cpu_cs low at least one cycle.
REQ-021 cpu_din SHALL hold last read value until next read LATCH.
REQ-022 cpu_cs dropping before ack (aborted cycle) SHALL still complete pending RAM strobe, then return IDLE without asserting dtack_n.
REQ-023 IRQ latch: write with lds_n=0 to IRQ_ADDR in ACCESS SHALL set latch (prot_irqn=0 from N+2); irq_ack=1 SHALL clear it next cycle; simultaneous set and ack -> set wins.
REQ-024 Reads of IRQ_ADDR SHALL NOT affect the IRQ latch.
REQ-025 main_addr/main_dout SHALL be stable whenever main_cs=1; main_wrn=1 whenever main_cs=0.

Reset
REQ-026 rst=1 SHALL force: state IDLE, dtack_n=1, main_cs=0, main_wrn=1, main_addr=0, main_dout=0, cpu_din=16'hFFFF, prot_irqn=1.
REQ-027 rst asserted mid-cycle SHALL abort immediately; no RAM strobe after the reset cycle; after release, cpu_cs already high is treated as a new cycle.

Verification
REQ-028 Read addr 11'h010, main_din=8'h5A: main_cs=1,main_wrn=1 at N+1; cpu_din=16'hFF5A, dtack_n=0 at N+3; dtack_n=1 one cycle after cpu_cs falls.
REQ-029 Write addr 11'h123, data 16'hBE42, lds_n=0: single main_cs pulse with main_addr=11'h123, main_dout=8'h42, main_wrn=0 at N+1; dtack_n=0 at N+2.
REQ-030 Write 11'h7ff -> prot_irqn=0 at N+2; irq_ack pulse -> prot_irqn=1; write plus irq_ack same ACCESS cycle -> prot_irqn stays 0.
REQ-031 Read with lds_n=1 -> no main_cs, cpu_din=16'hFFFF, dtack_n=0 at N+2.
REQ-032 rst pulse at N+2 of a read -> dtack_n=1, main_cs=0, cpu_din=16'hFFFF, state IDLE next cycle; read after release completes normally.
REQ-033 cpu_cs held 10 cycles -> exactly one main_cs pulse, dtack_n low until cs falls.
